// File: rtl/tick_timer_scheduler_if.sv
// rtl/tick_timer_scheduler_if.sv - command port bundle for the tick timer scheduler
interface tick_timer_scheduler_if #(
  parameter int CH_W  = 2,
  parameter int CNT_W = 8
);
  logic             cmd_valid;
  logic [1:0]       cmd_op;
  logic [CH_W-1:0]  cmd_ch;
  logic [CNT_W-1:0] cmd_load;
  logic             cmd_periodic;

  modport master (
    output cmd_valid, cmd_op, cmd_ch, cmd_load, cmd_periodic
  );

  modport slave (
    input cmd_valid, cmd_op, cmd_ch, cmd_load, cmd_periodic
  );
endinterface

// File: rtl/tick_timer_scheduler.sv
// rtl/tick_timer_scheduler.sv - N-channel countdown timers sharing one periodic tick
// A command on a channel takes priority over that channel's tick in the same cycle.
module tick_timer_scheduler #(
  parameter int N_CH  = 4,
  parameter int CH_W  = 2,
  parameter int CNT_W = 8
) (
  input  logic                 clkin,
  input  logic                 reset_n,
  input  logic                 tick,
  tick_timer_scheduler_if.slave cmd,
  input  logic [N_CH-1:0]      ack,
  input  logic [CH_W-1:0]      rd_ch,
  output logic [CNT_W-1:0]     rd_count,
  output logic [1:0]           rd_state,
  output logic [N_CH-1:0]      active,
  output logic [N_CH-1:0]      expire,
  output logic [N_CH-1:0]      pending,
  output logic                 irq,
  output logic                 cmd_err
);

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_PAUSE = 2'b10;

  localparam logic [1:0] OP_START  = 2'b00;
  localparam logic [1:0] OP_STOP   = 2'b01;
  localparam logic [1:0] OP_PAUSE  = 2'b10;

  logic [N_CH-1:0][1:0]       state_q, state_d;
  logic [N_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [N_CH-1:0][CNT_W-1:0] load_q, load_d;
  logic [N_CH-1:0]            periodic_q, periodic_d;
  logic [N_CH-1:0]            expire_q, expire_d;
  logic [N_CH-1:0]            pending_q, pending_d;
  logic                       irq_q, irq_d;
  logic                       cmd_err_q, cmd_err_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    load_d     = load_q;
    periodic_d = periodic_q;
    expire_d   = '0;
    cmd_err_d  = cmd.cmd_valid && (32'(cmd.cmd_ch) >= N_CH);

    for (int i = 0; i < N_CH; i++) begin
      if (cmd.cmd_valid && (cmd.cmd_ch == CH_W'(i))) begin
        case (cmd.cmd_op)
          OP_START: begin
            if (cmd.cmd_load != '0) begin
              load_d[i]     = cmd.cmd_load;
              cnt_d[i]      = cmd.cmd_load;
              periodic_d[i] = cmd.cmd_periodic;
              state_d[i]    = ST_RUN;
            end else begin
              cmd_err_d = 1'b1;
            end
          end
          OP_STOP: begin
            state_d[i] = ST_IDLE;
            cnt_d[i]   = '0;
          end
          OP_PAUSE: begin
            if (state_q[i] == ST_RUN) state_d[i] = ST_PAUSE;
            else                      cmd_err_d  = 1'b1;
          end
          default: begin
            if (state_q[i] == ST_PAUSE) state_d[i] = ST_RUN;
            else                        cmd_err_d  = 1'b1;
          end
        endcase
      end else if (tick && (state_q[i] == ST_RUN)) begin
        if (cnt_q[i] > CNT_W'(1)) begin
          cnt_d[i] = cnt_q[i] - CNT_W'(1);
        end else begin
          expire_d[i] = 1'b1;
          if (periodic_q[i]) begin
            cnt_d[i] = load_q[i];
          end else begin
            cnt_d[i]   = '0;
            state_d[i] = ST_IDLE;
          end
        end
      end
    end

    // A new expiry beats a simultaneous ack so no event is ever lost.
    pending_d = (pending_q & ~ack) | expire_d;
    irq_d     = |pending_d;
  end

  always_comb begin
    rd_count = '0;
    rd_state = ST_IDLE;
    for (int i = 0; i < N_CH; i++) begin
      if (rd_ch == CH_W'(i)) begin
        rd_count = cnt_q[i];
        rd_state = state_q[i];
      end
    end
  end

  always_comb begin
    active = '0;
    for (int i = 0; i < N_CH; i++) begin
      active[i] = (state_q[i] != ST_IDLE);
    end
  end

  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= '0;
      cnt_q      <= '0;
      load_q     <= '0;
      periodic_q <= '0;
      expire_q   <= '0;
      pending_q  <= '0;
      irq_q      <= 1'b0;
      cmd_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      load_q     <= load_d;
      periodic_q <= periodic_d;
      expire_q   <= expire_d;
      pending_q  <= pending_d;
      irq_q      <= irq_d;
      cmd_err_q  <= cmd_err_d;
    end
  end

  assign expire  = expire_q;
  assign pending = pending_q;
  assign irq     = irq_q;
  assign cmd_err = cmd_err_q;

endmodule
